// File: rtl/seq_detect_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// seq_detect_scheduler: round-robins a bank of pattern slots through one external serial
// sequence detector and attributes its matches. Build macro: SEQ_SCHED_CONTINUOUS_EN.
module seq_detect_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int WINDOW    = 16,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
    input  logic [7:0]                   cfg_pattern,
    input  logic [3:0]                   cfg_len,
    input  logic                         cfg_en,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    output logic [7:0]                   det_pattern,
    output logic [3:0]                   det_len,
    output logic                         det_clr,
    output logic                         det_valid,
    output logic                         det_bit,
    input  logic                         det_match,
    output logic                         busy,
    output logic                         hit,
    output logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         done
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int BCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WINDOW - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [7:0]          slot_pat_q [NUM_SLOTS];
    logic [3:0]          slot_len_q [NUM_SLOTS];
    logic                slot_en_q  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_ok;

    logic [2:0]          state_q, state_d;
    logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]          det_pattern_q, det_pattern_d;
    logic [3:0]          det_len_q, det_len_d;

    logic                found;
    logic [SLOT_W-1:0]   found_idx;

    logic                acc_q;
    logic [SLOT_W-1:0]   acc_slot_q;
    logic                hit_q;
    logic [SLOT_W-1:0]   hit_slot_q;
    logic [CNT_W-1:0]    match_cnt_q;
    logic                count_match;

    // Slot bank; writes are accepted in every state and regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_pat_q[i] <= '0;
                slot_len_q[i] <= '0;
                slot_en_q[i]  <= 1'b0;
            end
        end else if (cfg_we) begin
            slot_pat_q[cfg_addr] <= cfg_pattern;
            slot_len_q[cfg_addr] <= cfg_len;
            slot_en_q[cfg_addr]  <= cfg_en;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_ok[i] = slot_en_q[i] && (slot_len_q[i] != 4'd0) && (slot_len_q[i] <= 4'd8);
        end
    end

    // Lowest schedulable slot at or above the current position.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_ok[i] && (SLOT_W'(i) >= cur_slot_q)) begin
                found     = 1'b1;
                found_idx = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cur_slot_q    <= '0;
            bit_cnt_q     <= '0;
            det_pattern_q <= '0;
            det_len_q     <= '0;
        end else begin
            state_q       <= state_d;
            cur_slot_q    <= cur_slot_d;
            bit_cnt_q     <= bit_cnt_d;
            det_pattern_q <= det_pattern_d;
            det_len_q     <= det_len_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_slot_d    = cur_slot_q;
        bit_cnt_d     = bit_cnt_q;
        det_pattern_d = det_pattern_q;
        det_len_d     = det_len_q;
        if (ena) begin
            if (stop && (state_q != S_IDLE) && (state_q != S_FIN)) begin
                state_d = S_FIN;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !stop) begin
                            state_d    = S_SCAN;
                            cur_slot_d = '0;
                        end
                    end
                    S_SCAN: begin
                        if (found) begin
                            cur_slot_d = found_idx;
                            state_d    = S_LOAD;
`ifdef SEQ_SCHED_CONTINUOUS_EN
                        end else if (cur_slot_q != '0) begin
                            cur_slot_d = '0;
`endif
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                    S_LOAD: begin
                        det_pattern_d = slot_pat_q[cur_slot_q];
                        det_len_d     = slot_len_q[cur_slot_q];
                        bit_cnt_d     = '0;
                        state_d       = S_RUN;
                    end
                    S_RUN: begin
                        if (bit_valid) begin
                            if (bit_cnt_q == LAST_BIT) begin
                                if (cur_slot_q == LAST_SLOT) begin
`ifdef SEQ_SCHED_CONTINUOUS_EN
                                    cur_slot_d = '0;
                                    state_d    = S_SCAN;
`else
                                    state_d    = S_FIN;
`endif
                                end else begin
                                    cur_slot_d = cur_slot_q + SLOT_W'(1);
                                    state_d    = S_SCAN;
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                            end
                        end
                    end
                    S_FIN: begin
                        cur_slot_d = '0;
                        state_d    = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Pulses are qualified by ena so a frozen FSM never stretches them.
    always_comb begin
        det_clr   = ena && (state_q == S_LOAD);
        done      = ena && (state_q == S_FIN);
        busy      = (state_q != S_IDLE);
        det_valid = ena && bit_valid && (state_q == S_RUN);
        det_bit   = bit_in;
    end

    // The detector answers one cycle after an accepted bit, so acceptance is delayed to qualify it.
    assign count_match = ena && !stop && acc_q && det_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= 1'b0;
            acc_slot_q  <= '0;
            hit_q       <= 1'b0;
            hit_slot_q  <= '0;
            match_cnt_q <= '0;
        end else begin
            hit_q <= count_match;
            if (count_match) begin
                hit_slot_q <= acc_slot_q;
            end
            if (ena) begin
                acc_q <= det_valid && !stop;
                if (det_valid) begin
                    acc_slot_q <= cur_slot_q;
                end
            end
            if (ena && (state_q == S_IDLE) && start && !stop) begin
                match_cnt_q <= '0;
            end else if (count_match && (match_cnt_q != {CNT_W{1'b1}})) begin
                match_cnt_q <= match_cnt_q + CNT_W'(1);
            end
        end
    end

    assign det_pattern = det_pattern_q;
    assign det_len     = det_len_q;
    assign hit         = hit_q;
    assign hit_slot    = hit_slot_q;
    assign match_cnt   = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// tb_seq_detect_scheduler: directed and randomized passes checked against a schedule-level model.
module tb_seq_detect_scheduler;
    localparam int NS   = 4;
    localparam int W    = 16;
    localparam int CW   = 5;
    localparam int MAXC = 400;

    logic clk = 1'b0;
    logic rst_n, ena, cfg_we, cfg_en, start, stop, bit_valid, bit_in;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] det_pattern;
    logic [3:0] det_len;
    logic det_clr, det_valid, det_bit, det_match, busy, hit, done;
    logic [1:0] hit_slot;
    logic [CW-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pat [NS];
    logic [3:0] m_len [NS];
    logic       m_en  [NS];
    logic lv [MAXC];
    logic lb [MAXC];
    logic le [MAXC];
    int exp_clr[$];
    int exp_load[$];
    int exp_hits[$];
    int exp_done;

    always #5 clk = ~clk;

    seq_detect_scheduler #(.NUM_SLOTS(NS), .WINDOW(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_en(cfg_en),
        .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
        .det_pattern(det_pattern), .det_len(det_len), .det_clr(det_clr),
        .det_valid(det_valid), .det_bit(det_bit), .det_match(det_match),
        .busy(busy), .hit(hit), .hit_slot(hit_slot), .match_cnt(match_cnt), .done(done)
    );

    // Environment detector: registered match on the last det_len accepted bits since the flush.
    logic [7:0] hist;
    int nseen;
    function automatic logic env_match(logic [7:0] h, logic [7:0] p, logic [3:0] l);
        for (int j = 0; j < 8; j++) if (j < int'(l) && h[j] != p[j]) return 1'b0;
        return 1'b1;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0; nseen <= 0; det_match <= 1'b0;
        end else if (det_clr) begin
            hist <= '0; nseen <= 0; det_match <= 1'b0;
        end else if (det_valid) begin
            hist      <= {hist[6:0], det_bit};
            nseen     <= (nseen < 8) ? nseen + 1 : 8;
            det_match <= (det_len != 0) && (nseen + 1 >= int'(det_len)) &&
                         env_match({hist[6:0], det_bit}, det_pattern, det_len);
        end else begin
            det_match <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg(int s, logic [7:0] p, logic [3:0] l, logic e);
        cfg_we = 1'b1; cfg_addr = 2'(s); cfg_pattern = p; cfg_len = l; cfg_en = e;
        tick();
        cfg_we = 1'b0;
        m_pat[s] = p; m_len[s] = l; m_en[s] = e;
    endtask

    task automatic cfg_all_off();
        for (int s = 0; s < NS; s++) cfg(s, 8'h00, 4'd0, 1'b0);
    endtask

    function automatic int first_en(int p);
        while (p < MAXC && !le[p]) p++;
        return p;
    endfunction

    // Walks the schedule over the input log: every visited slot costs a SCAN and a LOAD
    // cycle, then takes the next W accepted bits with a freshly flushed history.
    task automatic build_expect();
        int p;
        int last_slot;
        int win[$];
        int l;
        bit ok;
        exp_clr.delete(); exp_load.delete(); exp_hits.delete();
        p = 0; last_slot = -1;
        for (int s = 0; s < NS; s++) begin
            l = int'(m_len[s]);
            if (!(m_en[s] && l >= 1 && l <= 8)) continue;
            p = first_en(p) + 1;
            p = first_en(p);
            exp_clr.push_back(p); exp_load.push_back(s);
            p++;
            win.delete();
            while (win.size() < W && p < MAXC) begin
                if (le[p] && lv[p]) win.push_back(int'(lb[p]));
                p++;
            end
            for (int k = l - 1; k < win.size(); k++) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++)
                    if (win[k - l + 1 + j] != int'(m_pat[s][l - 1 - j])) ok = 1'b0;
                if (ok) exp_hits.push_back(s);
            end
            last_slot = s;
        end
        if (last_slot != NS - 1) p = first_en(p) + 1;
        exp_done = first_en(p);
    endtask

    task automatic fill_plain();
        for (int c = 0; c < MAXC; c++) begin lv[c] = 1'b1; lb[c] = 1'b0; le[c] = 1'b1; end
    endtask

    // Window w of an uninterrupted run starts at cycle 2 + 18*w; bits[15] goes first.
    task automatic put_window(int w, logic [15:0] bits);
        for (int k = 0; k < W; k++) lb[2 + w * 18 + k] = bits[15 - k];
    endtask

    task automatic gen_log(bit all_ones);
        for (int c = 0; c < MAXC; c++) begin
            lv[c] = all_ones || ($urandom_range(0, 9) < 8);
            lb[c] = all_ones || ($urandom_range(0, 1) == 1);
            le[c] = (c == 0 || lv[c - 1]) ? 1'b1 : ($urandom_range(0, 9) < 8);
        end
    endtask

    task automatic run_pass(string tag);
        int dn;
        int clrs[$];
        int hits[$];
        logic [11:0] ld_q[$];
        bit prev_clr;
        int n;
        int sat;
        build_expect();
        ena = 1'b1; bit_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        dn = -1; prev_clr = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            ena = le[c]; bit_valid = lv[c]; bit_in = lb[c];
            #1;
            if (prev_clr) ld_q.push_back({det_len, det_pattern});
            prev_clr = det_clr;
            if (det_clr) clrs.push_back(c);
            if (hit) hits.push_back(int'(hit_slot));
            if (done && dn < 0) dn = c;
            tick();
            if (dn >= 0) break;
        end
        ena = 1'b1; bit_valid = 1'b0;
        #1;
        check({tag, " busy_after_done"}, int'(busy), 0);
        for (int t = 0; t < 3; t++) begin
            if (hit) hits.push_back(int'(hit_slot));
            tick();
        end
        check({tag, " done_cycle"}, dn, exp_done);
        check({tag, " clr_count"}, clrs.size(), exp_clr.size());
        n = (clrs.size() < exp_clr.size()) ? clrs.size() : exp_clr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " clr_cycle"}, clrs[i], exp_clr[i]);
            if (i < ld_q.size())
                check({tag, " loaded_cfg"}, int'(ld_q[i]),
                      int'({m_len[exp_load[i]], m_pat[exp_load[i]]}));
        end
        check({tag, " hit_count"}, hits.size(), exp_hits.size());
        n = (hits.size() < exp_hits.size()) ? hits.size() : exp_hits.size();
        for (int i = 0; i < n; i++) check({tag, " hit_slot"}, hits[i], exp_hits[i]);
        sat = (1 << CW) - 1;
        check({tag, " match_cnt"}, int'(match_cnt),
              (exp_hits.size() > sat) ? sat : exp_hits.size());
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0;
        cfg_len = '0; cfg_en = 1'b0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        for (int s = 0; s < NS; s++) begin m_pat[s] = '0; m_len[s] = '0; m_en[s] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst det_pattern", int'(det_pattern), 0);
        check("rst det_len", int'(det_len), 0);
        check("rst det_clr", int'(det_clr), 0);
        check("rst hit", int'(hit), 0);
        check("rst hit_slot", int'(hit_slot), 0);
        check("rst match_cnt", int'(match_cnt), 0);
        check("rst done", int'(done), 0);
        check("rst busy", int'(busy), 0);
        rst_n = 1'b1; ena = 1'b1;
        tick();

        // Single slot 101.
        cfg_all_off(); cfg(0, 8'b101, 4'd3, 1'b1);
        fill_plain(); put_window(0, 16'b1010_0000_0000_0000);
        run_pass("t1");

        // Slot 1 disabled and skipped; hits attributed 0 then 2.
        cfg(2, 8'b1101, 4'd4, 1'b1);
        fill_plain(); put_window(0, 16'b1010_0000_0000_0000); put_window(1, 16'b1101_0000_0000_0000);
        run_pass("t2");

        // Match on the final window bit.
        cfg_all_off(); cfg(0, 8'b0000, 4'd4, 1'b1);
        fill_plain(); put_window(0, 16'hFFF0);
        run_pass("t3");

        // Enabled slot with zero length is never scheduled.
        cfg_all_off(); cfg(1, 8'hFF, 4'd0, 1'b1);
        fill_plain();
        run_pass("t5");

        // Stop with a pending detector match.
        cfg_all_off(); cfg(0, 8'h01, 4'd1, 1'b1);
        ena = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("t4 cnt_before_stop", int'(match_cnt), 4);
        check("t4 hit_before_stop", int'(hit), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0; bit_valid = 1'b0;
        check("t4 done", int'(done), 1);
        check("t4 hit_suppressed", int'(hit), 0);
        check("t4 cnt_held", int'(match_cnt), 4);
        tick();
        check("t4 busy", int'(busy), 0);
        check("t4 hit_after", int'(hit), 0);
        check("t4 cnt_after", int'(match_cnt), 4);

        // start together with stop in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("idle_start_stop busy", int'(busy), 0);
        check("idle_start_stop done", int'(done), 0);

        // Config write to the active slot takes effect only on the next load.
        cfg_all_off(); cfg(0, 8'h03, 4'd2, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        cfg(0, 8'hA5, 4'd5, 1'b1);
        check("t6 pattern_held", int'(det_pattern), 8'h03);
        check("t6 len_held", int'(det_len), 2);
        stop = 1'b1; tick(); stop = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("t6 pattern_new", int'(det_pattern), 8'hA5);
        check("t6 len_new", int'(det_len), 5);
        stop = 1'b1; tick(); stop = 1'b0; tick(); tick();

        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < NS; s++)
                cfg(s, 8'($urandom), 4'($urandom_range(0, 9)), $urandom_range(0, 3) != 0);
            gen_log(1'b0);
            run_pass("rand");
        end

        // Every accepted bit matches, so the counter saturates.
        for (int s = 0; s < NS; s++) cfg(s, 8'h01, 4'd1, 1'b1);
        gen_log(1'b1);
        run_pass("saturate");

        // Asynchronous reset in the middle of a run clears state and the slot bank.
        ena = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst match_cnt", int'(match_cnt), 0);
        check("midrst det_len", int'(det_len), 0);
        check("midrst hit", int'(hit), 0);
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) begin m_pat[s] = '0; m_len[s] = '0; m_en[s] = 1'b0; end
        gen_log(1'b0);
        run_pass("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
